tx_feeder: RTL

- Transmit-side source for the transaction-layer router: the writer that feeds the router's main FIFO.
- Accepts 6-bit words from an upstream valid/ready interface and buffers them in a small internal FIFO.
- Pushes words into the router's main FIFO, honouring the router's registered pause.
- Sequences the router's init pulse and drives its FIFO threshold configuration.
- Keeps sent and stall statistics.

---
 rtl/tx_feeder_if.sv | 23 ++
 rtl/tx_feeder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tx_feeder_if.sv
// Word-level handshake between upstream source, tx_feeder and the router's main FIFO.
interface tx_feeder_if #(
  parameter int DATA_SIZE = 6
) ();
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 pause;
  logic                 push_main;
  logic [DATA_SIZE-1:0] data_in_o;

  // feeder side
  modport slave (
    input  in_data, in_valid, pause,
    output in_ready, push_main, data_in_o
  );

  // upstream source / router side
  modport master (
    output in_data, in_valid, pause,
    input  in_ready, push_main, data_in_o
  );
endinterface

// File: rtl/tx_feeder.sv
// Transmit-side writer for the router main FIFO: buffers upstream words,
// pushes them while the router is not paused, sequences init, keeps stats.
module tx_feeder #(
  parameter int         DATA_SIZE   = 6,
  parameter int         BUF_DEPTH   = 4,
  parameter int         INIT_CYCLES = 2,
  parameter logic [1:0] AF_MF       = 2'd3,
  parameter logic [1:0] AE_MF       = 2'd1,
  parameter logic [3:0] AF_VC       = 4'd12,
  parameter logic [3:0] AE_VC       = 4'd2,
  parameter logic [1:0] AF_DF       = 2'd3,
  parameter logic [1:0] AE_DF       = 2'd1
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        start,
  input  logic        stop,
  tx_feeder_if.slave  bus,
  output logic        init,
  output logic [1:0]  afMF_o,
  output logic [1:0]  aeMF_o,
  output logic [3:0]  afVC_o,
  output logic [3:0]  aeVC_o,
  output logic [1:0]  afDF_o,
  output logic [1:0]  aeDF_o,
  output logic        busy,
  output logic [15:0] sent_count,
  output logic [15:0] stall_count
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(INIT_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        icnt;
  logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 active, accept, issue, stall;

  // thresholds are static configuration for the router
  assign afMF_o = AF_MF;
  assign aeMF_o = AE_MF;
  assign afVC_o = AF_VC;
  assign aeVC_o = AE_VC;
  assign afDF_o = AF_DF;
  assign aeDF_o = AE_DF;

  assign active       = (state == RUN) || (state == DRAIN);
  assign bus.in_ready = (state == RUN) && (count < (AW+1)'(BUF_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  // pause is already registered by the router, so it is used as-is
  assign issue        = active && (count != '0) && !bus.pause;
  assign stall        = active && (count != '0) && bus.pause;
  assign busy         = (state != IDLE) || (count != '0);

  // control FSM; init is registered and high exactly while in INIT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      icnt  <= '0;
      init  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= INIT;
          icnt  <= CW'(INIT_CYCLES);
          init  <= 1'b1;
        end
        INIT: if (icnt == CW'(1)) begin
          state <= RUN;
          init  <= 1'b0;
        end else begin
          icnt <= icnt - CW'(1);
        end
        RUN:     if (stop) state <= DRAIN;
        DRAIN:   if ((count == '0) && !issue) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // buffer storage; contents need no reset, count/pointers gate validity
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.in_data;
  end

  // buffer pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (issue)  rd_ptr <= rd_ptr + AW'(1);
      case ({accept, issue})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // registered push to router; data holds between pushes
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.push_main <= 1'b0;
      bus.data_in_o <= '0;
    end else begin
      bus.push_main <= issue;
      if (issue) bus.data_in_o <= mem[rd_ptr];
    end
  end

  // saturating statistics, cleared only by reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sent_count  <= '0;
      stall_count <= '0;
    end else begin
      if (issue && (sent_count != 16'hFFFF))  sent_count  <= sent_count + 16'd1;
      if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
endmodule
